// File: rtl/vdp1_cmd_fetch.sv
// ---------------------------------------------------------------------------
// vdp1_cmd_fetch
//
// Walks the VDP1 command list in VRAM. It reads one 32-byte command table
// (CMDTBL_t) at a time and presents it to the draw engine. It then follows the
// jump mode (next / assign / call / return / skip) to the next table, and stops
// at a table whose END bit is set.
//
// Ports
//   CLK        in   1    system clock (sole clock)
//   RST        in   1    synchronous active-high reset (wins over CE)
//   CE         in   1    clock enable; all state advances only when CE=1
//   START      in   1    plot trigger; honoured only in IDLE
//   VRAM_A     out  18   VRAM word address (byte address bits [18:1])
//   VRAM_RD    out  1    read request; address held until VRAM_RDY
//   VRAM_D     in   16   read data, valid with VRAM_RDY
//   VRAM_RDY   in   1    read accept / data-valid strobe
//   CMD        out  256  assembled command table, word 0x00 in CMD[255:240]
//   CMD_VALID  out  1    CMD holds a complete command
//   CMD_DONE   in   1    draw engine finished the presented command
//   BUSY       out  1    list traversal in progress
//   CEF        out  1    list end reached
//   COPR       out  16   byte address/8 of the command being processed
//   LOPR       out  16   byte address/8 of the last handed-off/terminating cmd
// ---------------------------------------------------------------------------
module vdp1_cmd_fetch (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic         START,
    output logic [18:1]  VRAM_A,
    output logic         VRAM_RD,
    input  logic [15:0]  VRAM_D,
    input  logic         VRAM_RDY,
    output logic [255:0] CMD,
    output logic         CMD_VALID,
    input  logic         CMD_DONE,
    output logic         BUSY,
    output logic         CEF,
    output logic [15:0]  COPR,
    output logic [15:0]  LOPR
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_CTRL = 3'd1,
        RD_LINK = 3'd2,
        RD_BODY = 3'd3,
        PRESENT = 3'd4,
        NEXT    = 3'd5
    } state_t;

    state_t      state_r;
    logic [17:0] cur_r;          // word address of the current command table
    logic [17:0] ret_addr_r;     // single-level return address
    logic        ret_valid_r;
    logic [3:0]  word_idx_r;     // body word being fetched (2..14)
    logic [15:0] cmd_w_r [0:14]; // masked command words; word 15 is never read
    logic [17:0] vram_a_r;
    logic        vram_rd_r;
    logic        cmd_valid_r;
    logic        busy_r;
    logic        cef_r;
    logic [15:0] copr_r;
    logic [15:0] lopr_r;

    logic        rd_done_s;
    logic [3:0]  rd_idx_s;
    logic [15:0] rd_word_s;
    logic [2:0]  jp_s;
    logic [15:0] link_s;
    logic [17:0] seq_cur_s;
    logic [17:0] link_cur_s;
    logic [17:0] next_cur_s;

    // Per-word field mask: clears the reserved bits of each CMDTBL_t word.
    function automatic logic [15:0] word_mask(input logic [3:0] idx);
        logic [15:0] m;
        case (idx)
            4'd0:    m = 16'hFF3F;   // CMDCTRL
            4'd1:    m = 16'hFFFC;   // CMDLINK
            4'd2:    m = 16'h9FFF;   // CMDPMOD
            4'd4:    m = 16'hFFFC;   // CMDSRCA
            4'd5:    m = 16'h3FFF;   // CMDSIZE
            4'd15:   m = 16'h0000;   // dummy word
            default: m = 16'hFFFF;
        endcase
        return m;
    endfunction

    // Read completion, masked read word and next-command address selection.
    always_comb begin
        rd_done_s  = CE & vram_rd_r & VRAM_RDY;
        jp_s       = cmd_w_r[0][14:12];
        link_s     = cmd_w_r[1];
        seq_cur_s  = cur_r + 18'd16;
        link_cur_s = {link_s, 2'b00};

        case (state_r)
            RD_CTRL: rd_idx_s = 4'd0;
            RD_LINK: rd_idx_s = 4'd1;
            RD_BODY: rd_idx_s = word_idx_r;
            default: rd_idx_s = 4'd0;
        endcase
        rd_word_s = VRAM_D & word_mask(rd_idx_s);

        // JP[1:0]: 00 next, 01 assign, 10 call, 11 return.
        case (jp_s[1:0])
            2'b00: next_cur_s = seq_cur_s;
            2'b01: next_cur_s = link_cur_s;
            2'b10: next_cur_s = link_cur_s;
            2'b11: begin
                if (ret_valid_r) begin
                    next_cur_s = ret_addr_r;
                end else begin
                    next_cur_s = seq_cur_s;
                end
            end
            default: next_cur_s = seq_cur_s;
        endcase
    end

    // Command-list traversal FSM with all registered outputs and datapath.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            cur_r       <= 18'd0;
            ret_addr_r  <= 18'd0;
            ret_valid_r <= 1'b0;
            word_idx_r  <= 4'd0;
            vram_a_r    <= 18'd0;
            vram_rd_r   <= 1'b0;
            cmd_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            cef_r       <= 1'b0;
            copr_r      <= 16'd0;
            lopr_r      <= 16'd0;
            for (int k = 0; k < 15; k++) begin
                cmd_w_r[k] <= 16'h0000;
            end
        end else if (CE) begin
            case (state_r)
                IDLE: begin
                    if (START) begin
                        cur_r       <= 18'd0;
                        copr_r      <= 16'd0;
                        cef_r       <= 1'b0;
                        busy_r      <= 1'b1;
                        ret_valid_r <= 1'b0;
                        vram_a_r    <= 18'd0;
                        vram_rd_r   <= 1'b1;
                        state_r     <= RD_CTRL;
                    end
                end

                RD_CTRL: begin
                    if (rd_done_s) begin
                        cmd_w_r[0] <= rd_word_s;
                        if (rd_word_s[15]) begin
                            // END bit: list terminates, nothing is presented.
                            cef_r     <= 1'b1;
                            lopr_r    <= copr_r;
                            busy_r    <= 1'b0;
                            vram_rd_r <= 1'b0;
                            state_r   <= IDLE;
                        end else begin
                            vram_a_r <= cur_r + 18'd1;
                            state_r  <= RD_LINK;
                        end
                    end
                end

                RD_LINK: begin
                    if (rd_done_s) begin
                        cmd_w_r[1] <= rd_word_s;
                        if (jp_s[2]) begin
                            // Skip: the body is not fetched, go straight to the jump.
                            vram_rd_r <= 1'b0;
                            state_r   <= NEXT;
                        end else begin
                            vram_a_r   <= cur_r + 18'd2;
                            word_idx_r <= 4'd2;
                            state_r    <= RD_BODY;
                        end
                    end
                end

                RD_BODY: begin
                    if (rd_done_s) begin
                        cmd_w_r[word_idx_r] <= rd_word_s;
                        if (word_idx_r == 4'd14) begin
                            vram_rd_r   <= 1'b0;
                            cmd_valid_r <= 1'b1;
                            state_r     <= PRESENT;
                        end else begin
                            word_idx_r <= word_idx_r + 4'd1;
                            vram_a_r   <= cur_r + {14'd0, word_idx_r} + 18'd1;
                        end
                    end
                end

                PRESENT: begin
                    if (CMD_DONE) begin
                        cmd_valid_r <= 1'b0;
                        lopr_r      <= copr_r;
                        state_r     <= NEXT;
                    end
                end

                NEXT: begin
                    case (jp_s[1:0])
                        2'b10: begin
                            // Call overwrites any pending return (one level only).
                            ret_addr_r  <= seq_cur_s;
                            ret_valid_r <= 1'b1;
                        end
                        2'b11: ret_valid_r <= 1'b0;
                        default: ret_valid_r <= ret_valid_r;
                    endcase
                    cur_r     <= next_cur_s;
                    copr_r    <= next_cur_s[17:2];
                    vram_a_r  <= next_cur_s;
                    vram_rd_r <= 1'b1;
                    state_r   <= RD_CTRL;
                end

                default: begin
                    vram_rd_r   <= 1'b0;
                    cmd_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign VRAM_A    = vram_a_r;
    assign VRAM_RD   = vram_rd_r;
    assign CMD_VALID = cmd_valid_r;
    assign BUSY      = busy_r;
    assign CEF       = cef_r;
    assign COPR      = copr_r;
    assign LOPR      = lopr_r;

    for (genvar k = 0; k < 15; k++) begin : g_cmd
        assign CMD[255-16*k -: 16] = cmd_w_r[k];
    end
    assign CMD[15:0] = 16'h0000;

endmodule

// File: tb/tb_vdp1_cmd_fetch.sv
// ---------------------------------------------------------------------------
// tb_vdp1_cmd_fetch
//
// Self-checking bench for vdp1_cmd_fetch. A table of command-list scenarios
// (VRAM contents plus expected fetch order, hand-off count, COPR/LOPR and
// selected command words) is applied in a loop. Hand-written sequences cover
// reset, START->CMD_VALID latency, ignored START/CMD_DONE, stalls under a
// toggling CE, and reset while a command is presented.
// ---------------------------------------------------------------------------
module tb_vdp1_cmd_fetch;

    logic         CLK = 1'b0;
    logic         RST;
    logic         CE;
    logic         START;
    logic [18:1]  VRAM_A;
    logic         VRAM_RD;
    logic [15:0]  VRAM_D;
    logic         VRAM_RDY;
    logic [255:0] CMD;
    logic         CMD_VALID;
    logic         CMD_DONE;
    logic         BUSY;
    logic         CEF;
    logic [15:0]  COPR;
    logic [15:0]  LOPR;

    vdp1_cmd_fetch dut (
        .CLK(CLK), .RST(RST), .CE(CE), .START(START),
        .VRAM_A(VRAM_A), .VRAM_RD(VRAM_RD), .VRAM_D(VRAM_D), .VRAM_RDY(VRAM_RDY),
        .CMD(CMD), .CMD_VALID(CMD_VALID), .CMD_DONE(CMD_DONE),
        .BUSY(BUSY), .CEF(CEF), .COPR(COPR), .LOPR(LOPR)
    );

    always #5 CLK = ~CLK;

    logic [15:0] mem [0:262143];
    assign VRAM_D = mem[VRAM_A];

    int          checks   = 0;
    int          failures = 0;
    logic        ce_toggle;
    logic        ce_off;
    logic [17:0] stall_addr;
    int          stall_left;
    logic [17:0] rd_q [$];
    logic [17:0] exp_q [$];

    typedef struct packed {
        logic [2:0]       nwr;
        logic [5:0][17:0] wa;
        logic [5:0][15:0] wd;
        logic [2:0]       nst;
        logic [4:0][17:0] st;
        logic [4:0][3:0]  ln;
        logic [2:0]       nval;
        logic [15:0]      lopr;
        logic [15:0]      copr;
        logic [3:0][15:0] w;   // expected words 0,1,2,6 of the first command
    } scen_t;

    localparam int NSCEN = 7;
    scen_t tbl [0:NSCEN-1];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: inputs change at the falling edge; a read completing at the
    // next rising edge is recorded here.
    task automatic tick();
        @(negedge CLK);
        if (ce_off) CE = 1'b0;
        else if (ce_toggle) CE = ~CE;
        else CE = 1'b1;
        if (stall_left > 0 && VRAM_RD && VRAM_A == stall_addr) begin
            VRAM_RDY = 1'b0;
            stall_left--;
        end else begin
            VRAM_RDY = 1'b1;
        end
        if (CE && VRAM_RD && VRAM_RDY) rd_q.push_back(VRAM_A);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; CE = 1'b0; START = 1'b0; CMD_DONE = 1'b0; VRAM_RDY = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 262144; i++) mem[i] = 16'h0000;
    endtask

    task automatic add_run(input logic [17:0] start, input int len);
        logic [17:0] a;
        a = start;
        for (int k = 0; k < len; k++) begin
            exp_q.push_back(a);
            a = a + 18'd1;
        end
    endtask

    task automatic chk_reads(input string name);
        int bad;
        bad = -1;
        checks++;
        for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) begin
            if (bad < 0 && rd_q[i] !== exp_q[i]) bad = i;
        end
        if (rd_q.size() != exp_q.size() || bad >= 0) begin
            failures++;
            $display("FAIL %s reads=%0d required_reads=%0d first_bad_index=%0d", name, rd_q.size(), exp_q.size(), bad);
        end
    endtask

    task automatic set_wr(input int s, input int i, input logic [17:0] a, input logic [15:0] d);
        tbl[s].wa[i] = a;
        tbl[s].wd[i] = d;
        tbl[s].nwr   = 3'(i + 1);
    endtask

    task automatic set_st(input int s, input int i, input logic [17:0] a, input logic [3:0] l);
        tbl[s].st[i] = a;
        tbl[s].ln[i] = l;
        tbl[s].nst   = 3'(i + 1);
    endtask

    task automatic set_exp(input int s, input logic [2:0] nval, input logic [15:0] lopr,
                           input logic [15:0] copr, input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] w2, input logic [15:0] w6);
        tbl[s].nval = nval; tbl[s].lopr = lopr; tbl[s].copr = copr;
        tbl[s].w[0] = w0; tbl[s].w[1] = w1; tbl[s].w[2] = w2; tbl[s].w[3] = w6;
    endtask

    task automatic run_scen(input int s);
        int          cyc;
        int          nval;
        int          wait_n;
        logic        prev;
        logic [15:0] w0, w1, w2, w6;
        clear_mem();
        for (int i = 0; i < int'(tbl[s].nwr); i++) mem[tbl[s].wa[i]] = tbl[s].wd[i];
        ce_toggle = 1'b0; ce_off = 1'b0; stall_left = 0;
        do_reset();
        rd_q.delete();
        exp_q.delete();
        tick(); START = 1'b1;
        tick(); START = 1'b0;
        cyc = 0; nval = 0; wait_n = 0; prev = 1'b0;
        w0 = 16'h0; w1 = 16'h0; w2 = 16'h0; w6 = 16'h0;
        while (BUSY && cyc < 2000) begin
            tick();
            CMD_DONE = 1'b0;
            cyc++;
            if (CMD_VALID) begin
                if (!prev) begin
                    nval++;
                    if (nval == 1) begin
                        w0 = CMD[255:240]; w1 = CMD[239:224];
                        w2 = CMD[223:208]; w6 = CMD[159:144];
                    end
                end
                wait_n++;
                if (wait_n == 3) begin
                    CMD_DONE = 1'b1;
                    wait_n = 0;
                end
            end
            prev = CMD_VALID;
        end
        CMD_DONE = 1'b0;
        chk($sformatf("s%0d_timeout", s), 256'(cyc < 2000), 256'd1);
        chk($sformatf("s%0d_busy", s), 256'(BUSY), 256'd0);
        chk($sformatf("s%0d_cef", s), 256'(CEF), 256'd1);
        chk($sformatf("s%0d_nval", s), 256'(nval), 256'(tbl[s].nval));
        chk($sformatf("s%0d_lopr", s), 256'(LOPR), 256'(tbl[s].lopr));
        chk($sformatf("s%0d_copr", s), 256'(COPR), 256'(tbl[s].copr));
        for (int i = 0; i < int'(tbl[s].nst); i++) add_run(tbl[s].st[i], int'(tbl[s].ln[i]));
        chk_reads($sformatf("s%0d_fetch_order", s));
        if (tbl[s].nval != 3'd0) begin
            chk($sformatf("s%0d_w0", s), 256'(w0), 256'(tbl[s].w[0]));
            chk($sformatf("s%0d_w1", s), 256'(w1), 256'(tbl[s].w[1]));
            chk($sformatf("s%0d_w2", s), 256'(w2), 256'(tbl[s].w[2]));
            chk($sformatf("s%0d_w6", s), 256'(w6), 256'(tbl[s].w[3]));
        end
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 16'h0000; mem[1] = 16'h0000; mem[6] = 16'h0010; mem[16] = 16'h8000;
    endtask

    initial begin
        int lat;
        int n;
        int nv;
        RST = 1'b0; CE = 1'b0; START = 1'b0; CMD_DONE = 1'b0; VRAM_RDY = 1'b1;
        ce_toggle = 1'b0; ce_off = 1'b0; stall_addr = 18'd0; stall_left = 0;

        // ---------------- scenario table ----------------
        for (int s = 0; s < NSCEN; s++) tbl[s] = '0;
        // 0: one command, sequential to an END at word 16
        set_wr(0, 0, 18'h00000, 16'h0000); set_wr(0, 1, 18'h00001, 16'h0000);
        set_wr(0, 2, 18'h00006, 16'h0010); set_wr(0, 3, 18'h00010, 16'h8000);
        set_st(0, 0, 18'h00000, 4'd15); set_st(0, 1, 18'h00010, 4'd1);
        set_exp(0, 3'd1, 16'h0004, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0010);
        // 1: assign jump to byte 0x800
        set_wr(1, 0, 18'h00000, 16'h1000); set_wr(1, 1, 18'h00001, 16'h0100);
        set_wr(1, 2, 18'h00400, 16'h8000);
        set_st(1, 0, 18'h00000, 4'd15); set_st(1, 1, 18'h00400, 4'd1);
        set_exp(1, 3'd1, 16'h0100, 16'h0100, 16'h1000, 16'h0100, 16'h0000, 16'h0000);
        // 2: skip, only ctrl+link are read
        set_wr(2, 0, 18'h00000, 16'h4000); set_wr(2, 1, 18'h00010, 16'h8000);
        set_st(2, 0, 18'h00000, 4'd2); set_st(2, 1, 18'h00010, 4'd1);
        set_exp(2, 3'd0, 16'h0004, 16'h0004, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        // 3: call to 0x200, return to word 16
        set_wr(3, 0, 18'h00000, 16'h2000); set_wr(3, 1, 18'h00001, 16'h0040);
        set_wr(3, 2, 18'h00100, 16'h3000); set_wr(3, 3, 18'h00010, 16'h8000);
        set_st(3, 0, 18'h00000, 4'd15); set_st(3, 1, 18'h00100, 4'd15); set_st(3, 2, 18'h00010, 4'd1);
        set_exp(3, 3'd2, 16'h0004, 16'h0004, 16'h2000, 16'h0040, 16'h0000, 16'h0000);
        // 4: return with no call goes sequential; field masks applied
        set_wr(4, 0, 18'h00000, 16'h30FF); set_wr(4, 1, 18'h00001, 16'h0003);
        set_wr(4, 2, 18'h00002, 16'hFFFF); set_wr(4, 3, 18'h00006, 16'h1234);
        set_wr(4, 4, 18'h00010, 16'h8000);
        set_st(4, 0, 18'h00000, 4'd15); set_st(4, 1, 18'h00010, 4'd1);
        set_exp(4, 3'd1, 16'h0004, 16'h0004, 16'h303F, 16'h0000, 16'h9FFF, 16'h1234);
        // 5: second call overwrites the return address (272, not 16)
        set_wr(5, 0, 18'h00000, 16'h2000); set_wr(5, 1, 18'h00001, 16'h0040);
        set_wr(5, 2, 18'h00100, 16'h2000); set_wr(5, 3, 18'h00101, 16'h0080);
        set_wr(5, 4, 18'h00200, 16'h3000); set_wr(5, 5, 18'h00110, 16'h8000);
        set_st(5, 0, 18'h00000, 4'd15); set_st(5, 1, 18'h00100, 4'd15);
        set_st(5, 2, 18'h00200, 4'd15); set_st(5, 3, 18'h00110, 4'd1);
        set_exp(5, 3'd3, 16'h0044, 16'h0044, 16'h2000, 16'h0040, 16'h0000, 16'h0000);
        // 6: sequential step from the top of VRAM wraps to word 0
        set_wr(6, 0, 18'h00000, 16'h3000); set_wr(6, 1, 18'h00010, 16'h2000);
        set_wr(6, 2, 18'h00011, 16'hFFFC); set_wr(6, 3, 18'h3FFF0, 16'h0000);
        set_wr(6, 4, 18'h00020, 16'h8000);
        set_st(6, 0, 18'h00000, 4'd15); set_st(6, 1, 18'h00010, 4'd15);
        set_st(6, 2, 18'h3FFF0, 4'd15); set_st(6, 3, 18'h00000, 4'd15); set_st(6, 4, 18'h00020, 4'd1);
        set_exp(6, 3'd4, 16'h0008, 16'h0008, 16'h3000, 16'h0000, 16'h0000, 16'h0000);

        // ---------------- reset state, applied with CE low ----------------
        do_reset();
        chk("rst_outputs", 256'({VRAM_A, VRAM_RD, CMD_VALID, BUSY, CEF, COPR, LOPR}), 256'd0);
        chk("rst_cmd", CMD, 256'd0);

        // ---------------- latency, ignored START / CMD_DONE ----------------
        load_basic();
        do_reset();
        rd_q.delete(); exp_q.delete();
        tick(); START = 1'b1;
        tick(); START = 1'b0; CMD_DONE = 1'b1;
        lat = 1;
        while (!CMD_VALID && lat < 40) begin
            tick();
            lat++;
            CMD_DONE = (lat < 10);
        end
        CMD_DONE = 1'b0;
        chk("latency", 256'(lat), 256'd16);
        chk("present_rd_low", 256'(VRAM_RD), 256'd0);
        tick(); START = 1'b1;
        tick(); START = 1'b0;
        tick();
        chk("present_hold_valid", 256'(CMD_VALID), 256'd1);
        chk("present_busy", 256'(BUSY), 256'd1);
        chk("present_copr", 256'(COPR), 256'd0);
        chk("present_xa", 256'(CMD[159:144]), 256'h0010);
        CMD_DONE = 1'b1;
        tick(); CMD_DONE = 1'b0;
        chk("next_valid_low", 256'(CMD_VALID), 256'd0);
        chk("next_rd_low", 256'(VRAM_RD), 256'd0);
        chk("next_lopr", 256'(LOPR), 256'd0);
        tick();
        chk("next_addr", 256'(VRAM_A), 256'h00010);
        chk("next_copr", 256'(COPR), 256'h0004);
        n = 0;
        while (BUSY && n < 50) begin tick(); n++; end
        chk("end_cef", 256'(CEF), 256'd1);
        chk("end_lopr", 256'(LOPR), 256'h0004);
        add_run(18'h00000, 15); add_run(18'h00010, 1);
        chk_reads("basic_fetch_order");

        // ---------------- stall on word 3 with toggling CE, reset in PRESENT ----------------
        load_basic();
        do_reset();
        rd_q.delete(); exp_q.delete();
        ce_toggle = 1'b1; stall_addr = 18'h00003; stall_left = 5;
        START = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!BUSY && n < 10);
        START = 1'b0;
        n = 0;
        while (!CMD_VALID && n < 300) begin
            tick();
            n++;
            if (stall_left == 0 && VRAM_A == 18'h00003 && VRAM_RDY) begin
                chk("stall_addr_held", 256'(VRAM_RD), 256'd1);
            end
        end
        chk("stall_timeout", 256'(n < 300), 256'd1);
        chk("stall_consumed", 256'(stall_left), 256'd0);
        chk("stall_xa", 256'(CMD[159:144]), 256'h0010);
        add_run(18'h00000, 15);
        chk_reads("stall_fetch_order");
        ce_off = 1'b1;
        tick(); RST = 1'b1;
        tick(); RST = 1'b0;
        chk("rst_present_outputs", 256'({VRAM_A, VRAM_RD, CMD_VALID, BUSY, CEF, COPR, LOPR}), 256'd0);
        chk("rst_present_cmd", CMD, 256'd0);
        ce_off = 1'b0; ce_toggle = 1'b0;
        rd_q.delete();
        nv = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            CMD_DONE = ~CMD_DONE;
            if (CMD_VALID) nv++;
        end
        CMD_DONE = 1'b0;
        chk("rst_no_valid", 256'(nv), 256'd0);
        chk("rst_idle_busy", 256'(BUSY), 256'd0);
        chk("rst_no_reads", 256'(rd_q.size()), 256'd0);

        // ---------------- table-driven scenarios ----------------
        for (int s = 0; s < NSCEN; s++) run_scen(s);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vdp1_cmd_fetch.md
VDP1_CMD_FETCH -- requirements
Module: vdp1_cmd_fetch

Interface
REQ-001 CLK  in  1  system clock; sole clock.
REQ-002 RST  in  1  reset, synchronous, active-high.
REQ-003 CE  in  1  clock enable; state, counters and outputs advance only on CLK edges with CE=1.
REQ-004 START  in  1  plot-trigger pulse; begins list traversal at VRAM byte address 0.
REQ-005 VRAM_A  out  18  VRAM word address [18:1].
REQ-006 VRAM_RD  out  1  read request; held with VRAM_A stable until accepted.
REQ-007 VRAM_D  in  16  read data, valid when VRAM_RDY=1.
REQ-008 VRAM_RDY  in  1  read accept/data-valid strobe.
REQ-009 CMD  out  256  assembled command table (CMDTBL_t layout, word 0x00 in MSBs).
REQ-010 CMD_VALID  out  1  CMD holds a complete command for the draw engine.
REQ-011 CMD_DONE  in  1  draw engine finished the presented command.
REQ-012 BUSY  out  1  traversal in progress.
REQ-013 CEF  out  1  current end flag; list end reached.
REQ-014 COPR  out  16  byte address/8 of the command being processed.
REQ-015 LOPR  out  16  byte address/8 of the last command handed off or terminating.

Function
REQ-016 States SHALL be IDLE, RD_CTRL, RD_LINK, RD_BODY, PRESENT, NEXT.
REQ-017 IDLE: START=1 -> CUR=0, COPR=0, CEF=0, BUSY=1, return register cleared, go RD_CTRL; START outside IDLE ignored.
REQ-018 A read completes on a CE cycle with VRAM_RD=1 and VRAM_RDY=1; data captured that cycle; VRAM_RD may stay high with the next address on the following cycle.
REQ-019 Word k of a command SHALL be read from word address CUR+k (mod 2^18); CUR = {link,2'b00}.
REQ-020 RD_CTRL: read word 0, AND with 16'hFF3F; END=1 -> CEF=1, LOPR=COPR, BUSY=0, IDLE, no CMD_VALID; else RD_LINK.
REQ-021 RD_LINK: read word 1, AND with 16'hFFFC; JP[2]=1 (skip) -> NEXT without reading the body; else RD_BODY.
REQ-022 RD_BODY: read words 2..14 in order; masks PMOD 16'h9FFF, SRCA 16'hFFFC, SIZE 16'h3FFF, others 16'hFFFF; word 15 not read, driven 0.
REQ-023 PRESENT: CMD_VALID=1, CMD stable until CMD_DONE=1 on a CE cycle -> CMD_VALID=0 next cycle, LOPR=COPR, go NEXT.
REQ-024 NEXT (one cycle), by JP[1:0]: 00 next: CUR+16 words; 01 assign: link; 10 call: return register=CUR+16, valid=1, go link; 11 return: valid ? return address, valid=0 : CUR+16.
REQ-025 Call with return register already valid SHALL overwrite it (single-level nesting).
REQ-026 All address arithmetic SHALL wrap modulo 2^18 words (512 KB); COPR=CUR[17:2] updated on entry to RD_CTRL.
REQ-027 Minimum latency START -> CMD_VALID with VRAM_RDY tied high, CE=1: 16 cycles (1 setup + 15 reads).
REQ-028 CMD_DONE outside PRESENT SHALL be ignored.
REQ-029 VRAM_RD SHALL be 0 in IDLE, PRESENT and NEXT.

Reset
REQ-030 RST=1 on any CLK edge (regardless of CE) -> IDLE, VRAM_RD=0, VRAM_A=0, CMD=0, CMD_VALID=0, BUSY=0, CEF=0, COPR=0, LOPR=0, return register invalid.
REQ-031 RST mid-read or mid-present SHALL abandon the command; no CMD_VALID follows until a new START.

Verification
REQ-032 Cmd@0: CTRL=16'h0000, LINK=16'h0000, XA=16'h0010; cmd@0x20 CTRL=16'h8000; START -> one CMD_VALID with CMD[255:240]=0, XA field=16'h0010; after CMD_DONE reads word addr 16, CEF=1, BUSY=0, LOPR=16'h0004.
REQ-033 Cmd@0 CTRL=16'h1000 (assign), LINK=16'h0100; cmd@0x800 CTRL=16'h8000 -> after DONE next VRAM_A=18'h00400, COPR=16'h0100.
REQ-034 Skip: CTRL=16'h4000 @0 -> exactly 2 reads at words 0,1, no CMD_VALID, next read word 16.
REQ-035 Call/return: @0 CTRL=16'h2000 LINK=16'h0040; @0x200 CTRL=16'h3000; @0x20 END -> fetch order words 0,256,16; two CMD_VALIDs; return with no call -> next sequential.
REQ-036 VRAM_RDY low 5 cycles on word 3, CE toggling, RST asserted during PRESENT -> VRAM_A held stable while stalled; after RST all outputs 0, no CMD_VALID.
